// File: rtl/hw_barrier_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hw_barrier_pkg
//  Description : Shared register map, per-barrier register view and bus
//                address decode helpers for the hardware barrier array.
//  Revision    : 1.0 - initial release
// ============================================================================
package hw_barrier_pkg;

  localparam int IDX_W = 27;  // barrier index field: byte address bits [31:5]

  // Register offsets within one barrier's 0x20-byte window (word index add[4:2])
  localparam logic [2:0] OFF_TRIG_MASK = 3'd0;
  localparam logic [2:0] OFF_STATUS    = 3'd1;
  localparam logic [2:0] OFF_COUNT     = 3'd2;
  localparam logic [2:0] OFF_TARGET    = 3'd3;
  localparam logic [2:0] OFF_TRIGGER   = 3'd4;
  localparam logic [2:0] OFF_ABORT     = 3'd5;

  // Zero-extended view of one barrier's architectural registers
  typedef struct packed {
    logic [31:0] trig_mask;
    logic [31:0] target;
    logic [31:0] status;
    logic [31:0] count;
  } barr_regs_t;

  // Decoded word address: full barrier index (so out-of-range IDs never alias) and offset
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [2:0]       off;
  } bus_dec_t;

  // Splits a word address (byte address bits [31:2]) into barrier index and register offset
  function automatic bus_dec_t decode_bid(input logic [29:0] wadd);
    return bus_dec_t'(wadd);
  endfunction

  // Read view of one barrier; write-only and unmapped offsets read as zero
  function automatic logic [31:0] read_reg(input barr_regs_t r, input logic [2:0] off);
    case (off)
      OFF_TRIG_MASK: return r.trig_mask;
      OFF_STATUS:    return r.status;
      OFF_COUNT:     return r.count;
      OFF_TARGET:    return r.target;
      default:       return 32'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/hw_barrier_array_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hw_barrier_array_if
//  Description : Request/grant/response bus used by both the demuxed core
//                port and the peripheral interconnect port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hw_barrier_array_if;
  logic        req;
  logic        we_n;
  logic [31:0] add;
  logic [31:0] wdata;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;

  modport master (output req, we_n, add, wdata, input gnt, r_valid, r_rdata);
  modport slave  (input req, we_n, add, wdata, output gnt, r_valid, r_rdata);
endinterface
`default_nettype wire

// File: rtl/hw_barrier_slot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hw_barrier_slot
//  Description : One barrier: trigger mask, target mask, status, wrapping
//                match counter and match detection with trigger carry-over.
//  Revision    : 1.0 - initial release
// ============================================================================
module hw_barrier_slot
  import hw_barrier_pkg::*;
#(
  parameter int NB_CORES = 4,
  parameter int CNT_W    = 8
) (
  input  wire logic                clk_i,
  input  wire logic                rst_i,
  input  wire logic [NB_CORES-1:0] trig_i,       // merged new triggers this cycle
  input  wire logic                mask_we_i,
  input  wire logic                target_we_i,
  input  wire logic                abort_i,
  input  wire logic [NB_CORES-1:0] wdata_i,
  output logic                     match_o,
  output barr_regs_t               regs_o
);

  logic [NB_CORES-1:0] mask_q,   mask_d;
  logic [NB_CORES-1:0] target_q, target_d;
  logic [NB_CORES-1:0] status_q, status_d;
  logic [CNT_W-1:0]    count_q,  count_d;
  logic                w_match;

  // Match on registered state only; an empty mask never matches
  always_comb begin
    w_match = (mask_q != '0) && (status_q == mask_q);
  end

  // Next state: clearing writes beat a match, and a match restarts status from the new triggers
  always_comb begin
    mask_d   = mask_we_i   ? wdata_i : mask_q;
    target_d = target_we_i ? wdata_i : target_q;
    if (mask_we_i || abort_i) begin
      status_d = '0;
    end else if (w_match) begin
      status_d = trig_i;
    end else begin
      status_d = status_q | trig_i;
    end
    count_d = w_match ? count_q + CNT_W'(1) : count_q;
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q   <= '0;
      target_q <= '0;
      status_q <= '0;
      count_q  <= '0;
    end else begin
      mask_q   <= mask_d;
      target_q <= target_d;
      status_q <= status_d;
      count_q  <= count_d;
    end
  end

  // Suppress the event while reset is held so a pending match never fires during reset
  assign match_o = w_match & ~rst_i;

  // Zero-extended register view for the read mux and status summary
  always_comb begin
    regs_o                          = '0;
    regs_o.trig_mask[NB_CORES-1:0]  = mask_q;
    regs_o.target[NB_CORES-1:0]     = target_q;
    regs_o.status[NB_CORES-1:0]     = status_q;
    regs_o.count[CNT_W-1:0]         = count_q;
  end

endmodule
`default_nettype wire

// File: rtl/hw_barrier_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hw_barrier_array
//  Description : NB_BARR independent hardware barriers triggered by per-core
//                wires or bus writes; bus decode, write-conflict arbitration,
//                registered read mux and event OR.
//  Revision    : 1.0 - initial release
// ============================================================================
module hw_barrier_array
  import hw_barrier_pkg::*;
#(
  parameter  int NB_CORES = 4,
  parameter  int NB_BARR  = 8,
  parameter  int CNT_W    = 8,
  localparam int BID_W    = (NB_BARR > 1) ? $clog2(NB_BARR) : 1
) (
  input  wire logic                        clk_i,
  input  wire logic                        rst_i,
  input  wire logic [NB_CORES-1:0]         core_trig_i,
  input  wire logic [NB_CORES*BID_W-1:0]   core_trig_id_i,
  output logic      [NB_BARR*NB_CORES-1:0] barrier_status_o,
  output logic      [NB_CORES-1:0]         barrier_events_o,
  hw_barrier_array_if.slave                dmx,
  hw_barrier_array_if.slave                per
);

  logic        w_dmx_wr, w_per_conf, w_per_acc, w_wr_en, w_wr_ok;
  logic [31:0] w_wr_add, w_wr_data;
  bus_dec_t    w_wr_dec, w_dmx_dec, w_per_dec;
  logic        w_unused;

  barr_regs_t        w_regs [NB_BARR];
  logic [NB_BARR-1:0] w_match;

  logic             dmx_rd_q, dmx_ok_q, per_rd_q, per_ok_q, per_rvalid_q;
  logic [BID_W-1:0] dmx_bid_q, per_bid_q;
  logic [2:0]       dmx_off_q, per_off_q;

  // Conflict arbitration: the dmx port always wins, the per port is stalled on write/write
  assign w_dmx_wr   = dmx.req & ~dmx.we_n;
  assign w_per_conf = w_dmx_wr & per.req & ~per.we_n;
  assign per.gnt    = per.req & ~w_per_conf;
  assign w_per_acc  = per.req & per.gnt;
  assign dmx.gnt     = 1'b1;
  assign dmx.r_valid = 1'b1;

  // At most one write reaches the barriers per cycle, so both ports share a single write path
  assign w_wr_en   = w_dmx_wr | (w_per_acc & ~per.we_n);
  assign w_wr_add  = w_dmx_wr ? dmx.add   : per.add;
  assign w_wr_data = w_dmx_wr ? dmx.wdata : per.wdata;
  assign w_wr_dec  = decode_bid(w_wr_add[31:2]);
  assign w_wr_ok   = w_wr_en && (w_wr_dec.idx < IDX_W'(NB_BARR));
  assign w_dmx_dec = decode_bid(dmx.add[31:2]);
  assign w_per_dec = decode_bid(per.add[31:2]);
  assign w_unused  = ^{w_wr_add[1:0], w_wr_data};

  for (genvar b = 0; b < NB_BARR; b++) begin : g_slot
    logic                w_sel;
    logic [NB_CORES-1:0] w_trig;

    assign w_sel = w_wr_ok && (w_wr_dec.idx == IDX_W'(b));

    // Merge core trigger wires addressed to this barrier with a bus TRIGGER write
    always_comb begin
      w_trig = '0;
      for (int c = 0; c < NB_CORES; c++) begin
        if (core_trig_i[c] && (core_trig_id_i[c*BID_W +: BID_W] == BID_W'(b))) begin
          w_trig[c] = 1'b1;
        end
      end
      if (w_sel && (w_wr_dec.off == OFF_TRIGGER)) begin
        w_trig = w_trig | w_wr_data[NB_CORES-1:0];
      end
    end

    hw_barrier_slot #(
      .NB_CORES (NB_CORES),
      .CNT_W    (CNT_W)
    ) u_slot (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .trig_i      (w_trig),
      .mask_we_i   (w_sel && (w_wr_dec.off == OFF_TRIG_MASK)),
      .target_we_i (w_sel && (w_wr_dec.off == OFF_TARGET)),
      .abort_i     (w_sel && (w_wr_dec.off == OFF_ABORT)),
      .wdata_i     (w_wr_data[NB_CORES-1:0]),
      .match_o     (w_match[b]),
      .regs_o      (w_regs[b])
    );

    assign barrier_status_o[b*NB_CORES +: NB_CORES] = w_regs[b].status[NB_CORES-1:0];
  end

  // Events: OR of target masks of every barrier matching this cycle
  always_comb begin
    barrier_events_o = '0;
    for (int b = 0; b < NB_BARR; b++) begin
      if (w_match[b]) begin
        barrier_events_o = barrier_events_o | w_regs[b].target[NB_CORES-1:0];
      end
    end
  end

  // Read selectors: capture the request, data is muxed from the updated registers next cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmx_rd_q     <= 1'b0;
      dmx_ok_q     <= 1'b0;
      dmx_bid_q    <= '0;
      dmx_off_q    <= '0;
      per_rd_q     <= 1'b0;
      per_ok_q     <= 1'b0;
      per_bid_q    <= '0;
      per_off_q    <= '0;
      per_rvalid_q <= 1'b0;
    end else begin
      dmx_rd_q     <= dmx.req & dmx.we_n;
      dmx_ok_q     <= w_dmx_dec.idx < IDX_W'(NB_BARR);
      dmx_bid_q    <= w_dmx_dec.idx[BID_W-1:0];
      dmx_off_q    <= w_dmx_dec.off;
      per_rd_q     <= w_per_acc & per.we_n;
      per_ok_q     <= w_per_dec.idx < IDX_W'(NB_BARR);
      per_bid_q    <= w_per_dec.idx[BID_W-1:0];
      per_off_q    <= w_per_dec.off;
      per_rvalid_q <= w_per_acc;
    end
  end

  assign per.r_valid = per_rvalid_q;
  assign dmx.r_rdata = (dmx_rd_q && dmx_ok_q) ? read_reg(w_regs[dmx_bid_q], dmx_off_q) : 32'h0;
  assign per.r_rdata = (per_rd_q && per_ok_q) ? read_reg(w_regs[per_bid_q], per_off_q) : 32'h0;

endmodule
`default_nettype wire
